regfile_access_arbiter: RTL

Shares one register file write port and one read port among NUM_REQ requesters. Each requester uses a valid/ready handshake, and one transaction (read or write) is granted per cycle. Arbitration is round-robin, with an optional lock so one requester can own the file for an atomic read-modify-write sequence. The block sits between requester blocks (sequencers, DMA, debug) and the register file instance.

---
 rtl/regfile_access_arbiter_pkg.sv | 26 ++
 rtl/regfile_access_arbiter_rr_arbiter.sv | 38 +++
 rtl/regfile_access_arbiter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/regfile_access_arbiter_pkg.sv
// Shared types and the round-robin pick helper for the register file arbiter.
package regfile_arb_pkg;

  typedef enum logic {
    ARB_IDLE_RR = 1'b0,
    ARB_LOCKED  = 1'b1
  } arb_state_e;

  localparam int unsigned MAX_REQ = 32;
  localparam int unsigned MAX_IW  = 5;

  // One-hot grant: first set bit of valid at or after ptr, wrapping modulo n.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                 input int unsigned ptr,
                                                 input int unsigned n);
    logic [MAX_REQ-1:0] g;
    logic [MAX_IW-1:0]  idx;
    g = '0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      idx = MAX_IW'((ptr + k) % n);
      if (k < n && g == '0 && valid[idx]) g[idx] = 1'b1;
    end
    return g;
  endfunction

endpackage

// File: rtl/regfile_access_arbiter_rr_arbiter.sv
// Round-robin arbiter: combinational pick from a registered pointer that
// advances past the winner whenever a grant is taken.
module rr_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic               i_upd_en,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [PW-1:0]      o_idx
);

  logic [PW-1:0]      r_ptr;
  logic [MAX_REQ-1:0] w_pick;
  logic               w_unused_pick;

  assign w_pick        = rr_pick(MAX_REQ'(i_valid), 32'(r_ptr), NUM_REQ);
  assign o_grant       = w_pick[NUM_REQ-1:0];
  assign w_unused_pick = ^w_pick;

  always_comb begin
    o_idx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (o_grant[i]) o_idx = PW'(i);
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      r_ptr <= '0;
    else if (i_upd_en && |o_grant)
      r_ptr <= (o_idx == PW'(NUM_REQ - 1)) ? '0 : o_idx + 1'b1;
  end

endmodule

// File: rtl/regfile_access_arbiter.sv
// Shares one register-file write port and one read port among NUM_REQ
// requesters, round-robin, with a lock for atomic read-modify-write.
module regfile_access_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int WORD_LENGTH  = 8,
  parameter int REG_AMOUNT   = 8,
  parameter int LOCK_TIMEOUT = 16,
  localparam int AW = (REG_AMOUNT > 1) ? $clog2(REG_AMOUNT) : 1,
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ-1:0]             req_write,
  input  logic [NUM_REQ-1:0]             req_lock,
  input  logic [NUM_REQ*AW-1:0]          req_addr,
  input  logic [NUM_REQ*WORD_LENGTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [WORD_LENGTH-1:0]         rsp_data,
  output logic                           lock_owner_valid,
  output logic [PW-1:0]                  lock_owner,
  output logic                           rf_wrEn,
  output logic [AW-1:0]                  rf_addrWrite,
  output logic [AW-1:0]                  rf_addrRead,
  output logic [WORD_LENGTH-1:0]         rf_dataIn,
  input  logic [WORD_LENGTH-1:0]         rf_dataOut
);

  localparam int CW = $clog2(LOCK_TIMEOUT + 1);

  arb_state_e r_state, w_next_state;
  logic [PW-1:0]      r_owner;
  logic [CW-1:0]      r_idle;
  logic               r_rsp_vld;
  logic [PW-1:0]      r_rsp_id;

  logic [NUM_REQ-1:0] w_owner_oh;
  logic [NUM_REQ-1:0] w_elig;
  logic [NUM_REQ-1:0] w_grant;
  logic [PW-1:0]      w_win;
  logic               w_any;
  logic               w_win_write;
  logic               w_win_lock;
  logic               w_owner_idle;

  logic [NUM_REQ-1:0][AW-1:0]          w_addr_v;
  logic [NUM_REQ-1:0][WORD_LENGTH-1:0] w_wdata_v;

  assign w_addr_v     = req_addr;
  assign w_wdata_v    = req_wdata;
  assign w_owner_oh   = NUM_REQ'(1) << r_owner;
  assign w_any        = |w_grant;
  assign w_win_write  = req_write[w_win];
  assign w_win_lock   = req_lock[w_win];
  assign w_owner_idle = !req_valid[r_owner];

  // While locked only the owner can be picked, which also parks the
  // pointer at owner+1 so arbitration resumes there after release.
  always_comb begin
    w_elig = '0;
    if (rst_n)
      w_elig = (r_state == ARB_LOCKED) ? (req_valid & w_owner_oh) : req_valid;
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_valid  (w_elig),
    .i_upd_en (1'b1),
    .o_grant  (w_grant),
    .o_idx    (w_win)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ARB_IDLE_RR;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ARB_IDLE_RR:
        if (w_any && w_win_lock) w_next_state = ARB_LOCKED;
      ARB_LOCKED:
        if (w_any && !w_win_lock)
          w_next_state = ARB_IDLE_RR;
        else if (w_owner_idle && r_idle == CW'(LOCK_TIMEOUT - 1))
          w_next_state = ARB_IDLE_RR;
      default: w_next_state = ARB_IDLE_RR;
    endcase
  end

  always_comb begin
    lock_owner_valid = (r_state == ARB_LOCKED);
    lock_owner       = r_owner;
    req_ready        = w_grant;
    rf_wrEn          = w_any && w_win_write;
    rf_addrWrite     = w_any ? w_addr_v[w_win] : '0;
    rf_addrRead      = w_any ? w_addr_v[w_win] : '0;
    rf_dataIn        = (w_any && w_win_write) ? w_wdata_v[w_win] : '0;
    rsp_valid        = (rst_n && r_rsp_vld) ? (NUM_REQ'(1) << r_rsp_id) : '0;
    rsp_data         = rf_dataOut;
  end

  // Idle counter only runs while staying locked with the owner silent.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_owner   <= '0;
      r_idle    <= '0;
      r_rsp_vld <= 1'b0;
      r_rsp_id  <= '0;
    end else begin
      if (r_state == ARB_IDLE_RR && w_any && w_win_lock) r_owner <= w_win;
      if (r_state != ARB_LOCKED || w_next_state != ARB_LOCKED || w_any)
        r_idle <= '0;
      else
        r_idle <= r_idle + 1'b1;
      r_rsp_vld <= w_any && !w_win_write;
      r_rsp_id  <= w_win;
    end
  end

endmodule
